fdivider: RTL and testbench

- Sequential IEEE-754 single-precision divider computing result = A / B; the inverse operation to the team's floating-point multiplier.
- Uses iterative radix-2 restoring mantissa division, one quotient bit per cycle.
- Sits beside the multiplier in the floating-point calculator and serves normalisation and scaling steps in the DNN datapath.
- Valid/ready handshake on input and output; one operation in flight at a time.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_classify.sv | 25 ++
 rtl/fdivider.sv | 176 +++++++++++++++++
 tb/tb_fdivider.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, special encodings and
// the sequential divider's state encoding.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_DIV   = 3'd2,
      ST_ROUND = 3'd3,
      ST_DONE  = 3'd4
   } div_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: zero (subnormals flushed), inf, NaN
// and the mantissa with its hidden bit restored.
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0]     op,
   output logic            sign,
   output logic            is_zero,
   output logic            is_inf,
   output logic            is_nan,
   output logic [FRAC_W:0] mant
);

   logic [EXP_W-1:0]  exp_s;
   logic [FRAC_W-1:0] frac_s;

   assign exp_s   = op[30:23];
   assign frac_s  = op[22:0];
   assign sign    = op[31];
   assign is_zero = (exp_s == 8'h00);
   assign is_inf  = (exp_s == 8'hFF) && (frac_s == 23'd0);
   assign is_nan  = (exp_s == 8'hFF) && (frac_s != 23'd0);
   assign mant    = {1'b1, frac_s};

endmodule

// File: rtl/fdivider.sv
// Sequential single-precision divider, result = A / B, using radix-2
// restoring mantissa division (one quotient bit per cycle) and RNE rounding.
module fdivider #(
   parameter int BIAS = fp_pkg::BIAS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        exception
);
   import fp_pkg::*;

   div_state_t  state_r;
   logic [31:0] a_r, b_r;
   logic [24:0] rem_r;
   logic [23:0] q_r;
   logic [4:0]  cnt_r;
   logic [9:0]  exp_r;
   logic        sign_r;

   logic        a_sign_s, a_zero_s, a_inf_s, a_nan_s;
   logic        b_sign_s, b_zero_s, b_inf_s, b_nan_s;
   logic [23:0] a_mant_s, b_mant_s;

   fp_classify u_class_a (
      .op(a_r), .sign(a_sign_s), .is_zero(a_zero_s), .is_inf(a_inf_s),
      .is_nan(a_nan_s), .mant(a_mant_s)
   );

   fp_classify u_class_b (
      .op(b_r), .sign(b_sign_s), .is_zero(b_zero_s), .is_inf(b_inf_s),
      .is_nan(b_nan_s), .mant(b_mant_s)
   );

   logic        sign_s, special_s, spec_exc_s, adj_s;
   logic [31:0] spec_res_s;
   logic [24:0] rem_init_s;
   logic [9:0]  exp_prep_s;

   // Operand classification, special-case results and normal-path setup.
   always_comb begin
      sign_s     = a_sign_s ^ b_sign_s;
      special_s  = 1'b1;
      spec_exc_s = 1'b0;
      spec_res_s = 32'd0;
      if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
         spec_res_s = QNAN;
         spec_exc_s = 1'b1;
      end else if (b_zero_s) begin
         spec_res_s = {sign_s, POS_INF[30:0]};
         spec_exc_s = 1'b1;
      end else if (a_zero_s || b_inf_s) begin
         spec_res_s = {sign_s, 31'd0};
      end else if (a_inf_s) begin
         spec_res_s = {sign_s, POS_INF[30:0]};
      end else begin
         special_s = 1'b0;
      end
      adj_s      = (a_mant_s < b_mant_s);
      rem_init_s = adj_s ? {a_mant_s, 1'b0} : {1'b0, a_mant_s};
      exp_prep_s = {2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + 10'(BIAS) - {9'd0, adj_s};
   end

   logic        rem_ge_s;
   logic [24:0] rem_sel_s, rem_next_s;

   // One restoring-division step.
   always_comb begin
      rem_ge_s = (rem_r >= {1'b0, b_mant_s});
      if (rem_ge_s) begin
         rem_sel_s = rem_r - {1'b0, b_mant_s};
      end else begin
         rem_sel_s = rem_r;
      end
      rem_next_s = rem_sel_s << 1;
   end

   logic        inc_s, frac_carry_s, round_exc_s;
   logic [22:0] frac_rnd_s;
   logic [9:0]  exp_fin_s;
   logic [31:0] round_res_s;

   // Round to nearest even and range-check the final exponent. The leading
   // quotient bit is always 1 and has already been shifted out of q_r.
   always_comb begin
      inc_s                      = q_r[0] & ((|rem_r) | q_r[1]);
      {frac_carry_s, frac_rnd_s} = {1'b0, q_r[23:1]} + {23'd0, inc_s};
      exp_fin_s                  = exp_r + {9'd0, frac_carry_s};
      round_exc_s                = 1'b0;
      if ($signed(exp_fin_s) >= 10'sd255) begin
         round_res_s = {sign_r, POS_INF[30:0]};
         round_exc_s = 1'b1;
      end else if ($signed(exp_fin_s) <= 10'sd0) begin
         round_res_s = {sign_r, 31'd0};
      end else begin
         round_res_s = {sign_r, exp_fin_s[7:0], frac_rnd_s};
      end
   end

   // Control FSM and datapath registers; out_valid rises the cycle after DONE is entered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= 32'd0;
         exception <= 1'b0;
         a_r       <= 32'd0;
         b_r       <= 32'd0;
         rem_r     <= 25'd0;
         q_r       <= 24'd0;
         cnt_r     <= 5'd0;
         exp_r     <= 10'd0;
         sign_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r      <= A;
                  b_r      <= B;
                  in_ready <= 1'b0;
                  state_r  <= ST_PREP;
               end
            end
            ST_PREP: begin
               sign_r <= sign_s;
               if (special_s) begin
                  result    <= spec_res_s;
                  exception <= spec_exc_s;
                  state_r   <= ST_DONE;
               end else begin
                  rem_r   <= rem_init_s;
                  q_r     <= 24'd0;
                  cnt_r   <= 5'd0;
                  exp_r   <= exp_prep_s;
                  state_r <= ST_DIV;
               end
            end
            ST_DIV: begin
               rem_r <= rem_next_s;
               q_r   <= {q_r[22:0], rem_ge_s};
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == 5'd24) begin
                  state_r <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               result    <= round_res_s;
               exception <= round_exc_s;
               state_r   <= ST_DONE;
            end
            ST_DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdivider.sv
// Scoreboard bench for fdivider: directed table plus randomized operands
// checked against an integer-arithmetic reference of IEEE division.
module tb_fdivider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        in_ready, out_valid, exception;
   logic [31:0] result;

   fdivider dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .exception(exception)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
      int          acc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   ready_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: exact quotient via 64-bit integer division, then RNE.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic exc, output int lat);
      bit     az, ai, an, bz, bi, bn, sg, g, st;
      longint ma, mb, num, qq, rm, mant;
      int     e;
      az = (a[30:23] == 8'h00);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      bz = (b[30:23] == 8'h00);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      sg = a[31] ^ b[31];
      exc = 1'b0;
      lat = 2;
      if (an || bn || (az && bz) || (ai && bi)) begin
         res = 32'h7FC0_0000;
         exc = 1'b1;
      end else if (bz) begin
         res = {sg, 31'h7F80_0000};
         exc = 1'b1;
      end else if (az || bi) begin
         res = {sg, 31'd0};
      end else if (ai) begin
         res = {sg, 31'h7F80_0000};
      end else begin
         lat = 28;
         ma  = longint'({1'b1, a[22:0]});
         mb  = longint'({1'b1, b[22:0]});
         num = ma << 25;
         qq  = num / mb;
         rm  = num % mb;
         e   = int'(a[30:23]) - int'(b[30:23]) + 127;
         if (qq >= (longint'(1) << 25)) begin
            mant = qq >> 2;
            g    = qq[1];
            st   = qq[0] || (rm != 0);
         end else begin
            mant = qq >> 1;
            g    = qq[0];
            st   = (rm != 0);
            e    = e - 1;
         end
         if (g && (st || mant[0])) mant = mant + 1;
         if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e    = e + 1;
         end
         if (e >= 255) begin
            res = {sg, 31'h7F80_0000};
            exc = 1'b1;
         end else if (e <= 0) begin
            res = {sg, 31'd0};
         end else begin
            res = {sg, 8'(e), 23'(mant)};
         end
      end
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      int          sel;
      v   = $urandom;
      sel = $urandom_range(0, 11);
      case (sel)
         0: v[30:23] = 8'h00;
         1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
         3: v[30:23] = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'hFE;
         4: v[22:0] = 23'd0;
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   // Offer one operation; push the expectation at the accept edge when wanted.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                        input logic [31:0] res, input logic exc, input int lat);
      exp_t e;
      int   w;
      w = 0;
      @(posedge clk); #2;
      A = a; B = b; in_valid = 1'b1;
      while (!in_ready && w < 200) begin
         @(posedge clk); #2;
         w++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = $urandom; B = $urandom;
      if (push) begin
         e.a = a; e.b = b; e.res = res; e.exc = exc; e.lat = lat; e.acc = cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        x;
      int          l;
      model(a, b, r, x, l);
      issue(a, b, 1'b1, r, x, l);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(posedge clk);
         w++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (4) @(posedge clk);
   endtask

   // Consumer-side backpressure pattern.
   initial forever begin
      @(posedge clk); #2;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: latency on out_valid rise, stability while stalled, compare on handshake.
   initial begin
      bit          prev_valid;
      logic [31:0] held_res;
      logic        held_exc;
      exp_t        e;
      prev_valid = 1'b0;
      held_res   = 32'd0;
      held_exc   = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               if (exp_q.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
               else check($sformatf("latency %h/%h", exp_q[0].a, exp_q[0].b),
                          32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
               held_res = result;
               held_exc = exception;
            end else if (out_valid) begin
               check("hold_result", result, held_res);
               check("hold_exception", 32'(exception), 32'(held_exc));
            end
            if (out_valid) check("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check($sformatf("result %h/%h", e.a, e.b), result, e.res);
               check($sformatf("exception %h/%h", e.a, e.b), 32'(exception), 32'(e.exc));
            end
            prev_valid = out_valid;
         end
      end
   end

   localparam logic [31:0] DA [13] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
      32'h7F000000, 32'h00800000, 32'hC0C00000, 32'hFF800000, 32'h3F800000, 32'h7F800001,
      32'h7F800000, 32'hC0000000, 32'h00400000};
   localparam logic [31:0] DB [13] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
      32'h00800000, 32'h7F000000, 32'h40000000, 32'h40000000, 32'hFF800000, 32'h3F800000,
      32'h7F800000, 32'h00000000, 32'h3F800000};
   localparam logic [31:0] DR [13] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000,
      32'h7F800000, 32'h00000000, 32'hC0400000, 32'hFF800000, 32'h80000000, 32'h7FC00000,
      32'h7FC00000, 32'hFF800000, 32'h00000000};
   localparam logic DX [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
      1'b1, 1'b1, 1'b0};
   localparam int DL [13] = '{28, 28, 2, 2, 28, 28, 28, 2, 2, 2, 2, 2, 2};

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_exception", 32'(exception), 32'd0);
      #1 reset_n = 1'b1;

      for (int i = 0; i < 13; i++) issue(DA[i], DB[i], 1'b1, DR[i], DX[i], DL[i]);
      drain();

      // Backpressure: hold out_ready low well past out_valid.
      ready_mode = 2;
      issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0, 28);
      w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("bp_out_valid_seen", 32'(out_valid), 32'd1);
      repeat (10) @(posedge clk);
      ready_mode = 0;
      drain();

      // in_valid pulsed while busy must be ignored.
      issue(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 1'b0, 28);
      repeat (3) @(posedge clk);
      #2;
      A = 32'h40000000; B = 32'h3F800000; in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #2 in_valid = 1'b0;
      drain();

      // Reset during DIV abandons the operation.
      issue(32'h40C00000, 32'h40000000, 1'b0, 32'd0, 1'b0, 0);
      repeat (10) @(posedge clk);
      #2 reset_n = 1'b0;
      @(posedge clk); #1;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_in_ready", 32'(in_ready), 32'd1);
      check("midreset_result", result, 32'd0);
      #1 reset_n = 1'b1;
      issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0, 28);
      drain();

      ready_mode = 1;
      for (int i = 0; i < 150; i++) issue_model(rand_fp(), rand_fp());
      ready_mode = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
